// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of the shared lab memory arbiter.
// The arbiter connects through the slave modport; the requester/memory environment uses master.
interface mem_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 5,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rdata;
  logic               busy;
  logic               mem_read;
  logic               mem_write;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_din;
  logic [DW-1:0]      mem_dout;

  modport slave (
    input  req, we, addr, wdata, mem_dout,
    output gnt, done, rdata, busy, mem_read, mem_write, mem_addr, mem_din
  );

  modport master (
    output req, we, addr, wdata, mem_dout,
    input  gnt, done, rdata, busy, mem_read, mem_write, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that serialises single read/write transactions from NREQ
// requesters onto one single-port memory with a 1-cycle registered read.
module mem_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 5,
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_arbiter_if.slave    bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RWAIT,
    DONE
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   last_owner_q;
  logic            we_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic [DW-1:0]   rdata_q;
  logic            busy_q;
  logic            mem_read_q;
  logic            mem_write_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_din_q;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;

  // Scan from the requester after the last owner, wrapping NREQ-1 -> 0.
  // NOTE: every variable gets a default before any conditional write so no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = last_owner_q;
    for (int i = 0; i < NREQ; i++) begin
      cand = (cand == IW'(NREQ - 1)) ? '0 : cand + IW'(1);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= IW'(NREQ - 1);
      we_q         <= 1'b0;
      gnt_q        <= '0;
      done_q       <= '0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_found) begin
            owner_q     <= win_idx;
            we_q        <= bus.we[win_idx];
            gnt_q       <= NREQ'(1) << win_idx;
            busy_q      <= 1'b1;
            mem_addr_q  <= bus.addr[win_idx*AW +: AW];
            mem_write_q <= bus.we[win_idx];
            mem_read_q  <= ~bus.we[win_idx];
            // Write data is only taken from a writing winner so a read never pulls in stale X.
            if (bus.we[win_idx]) begin
              mem_din_q <= bus.wdata[win_idx*DW +: DW];
            end
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_write_q <= 1'b0;
          mem_read_q  <= 1'b0;
          if (we_q) begin
            done_q  <= gnt_q;
            state_q <= DONE;
          end else begin
            state_q <= RWAIT;
          end
        end
        RWAIT: begin
          rdata_q <= bus.mem_dout;
          done_q  <= gnt_q;
          state_q <= DONE;
        end
        DONE: begin
          done_q       <= '0;
          gnt_q        <= '0;
          busy_q       <= 1'b0;
          last_owner_q <= owner_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;

endmodule
